// File: rtl/addsub_acc_pipe.sv
// Two-stage, back-pressurable multi-lane add/sub/accumulate datapath.
// Stage 1 captures operands; stage 2 computes per-lane results and owns the lane accumulators.

package addsub_acc_pipe_pkg;
   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ACC  = 2'b10,
      OP_LOAD = 2'b11
   } op_e;
endpackage

// One lane of stage-2 arithmetic: purely combinational, evaluated on the stage-1 operands.
module addsub_acc_lane
   import addsub_acc_pipe_pkg::*;
#(
   parameter int N = 32
) (
   input  op_e          mode,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] acc,
   input  logic         clear,
   output logic [N-1:0] data,
   output logic         carry,
   output logic         acc_wr,
   output logic         parity
);
   logic [N-1:0] acc_base;
   logic [N:0]   sum_ab;
   logic [N:0]   sum_acc_a;
   logic [N:0]   sum_acc_ab;

   // A clear landing on the same edge as an ACC beat zeroes the base before the add.
   assign acc_base   = clear ? '0 : acc;
   assign sum_ab     = {1'b0, a} + {1'b0, b};
   assign sum_acc_a  = {1'b0, acc_base} + {1'b0, a};
   assign sum_acc_ab = {1'b0, sum_acc_a[N-1:0]} + {1'b0, b};
   assign parity     = ^a;

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      data   = '0;
      carry  = 1'b0;
      acc_wr = 1'b0;
      case (mode)
         OP_ADD: begin
            data  = sum_ab[N-1:0];
            carry = sum_ab[N];
         end
         OP_SUB: begin
            data  = a - b;
            carry = (a < b);
         end
         OP_ACC: begin
            data   = sum_acc_ab[N-1:0];
            carry  = sum_acc_a[N] | sum_acc_ab[N];
            acc_wr = 1'b1;
         end
         OP_LOAD: begin
            data   = a;
            acc_wr = 1'b1;
         end
         default: begin
            data = '0;
         end
      endcase
   end
endmodule

module addsub_acc_pipe
   import addsub_acc_pipe_pkg::*;
#(
   parameter int N   = 32,
   parameter int NCH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               IN_valid,
   output logic               IN_ready,
   input  logic [2*NCH-1:0]   IN_mode,
   input  logic [NCH*N-1:0]   IN_dataA,
   input  logic [NCH*N-1:0]   IN_dataB,
   input  logic               IN_clear,
   output logic               OUT_valid,
   input  logic               OUT_ready,
   output logic [NCH*N-1:0]   OUT_data,
   output logic [NCH-1:0]     OUT_carry,
   output logic [NCH-1:0]     OUT_parity
);
   logic               s1_valid_q,  s1_valid_d;
   logic [2*NCH-1:0]   s1_mode_q,   s1_mode_d;
   logic [NCH*N-1:0]   s1_a_q,      s1_a_d;
   logic [NCH*N-1:0]   s1_b_q,      s1_b_d;
   logic               s2_valid_q,  s2_valid_d;
   logic [NCH*N-1:0]   s2_data_q,   s2_data_d;
   logic [NCH-1:0]     s2_carry_q,  s2_carry_d;
   logic [NCH-1:0]     s2_parity_q, s2_parity_d;
   logic [NCH*N-1:0]   acc_q,       acc_d;

   logic               in_fire;
   logic               s2_load;
   logic [NCH*N-1:0]   lane_data;
   logic [NCH-1:0]     lane_carry;
   logic [NCH-1:0]     lane_acc_wr;
   logic [NCH-1:0]     lane_parity;

   // Stage 2 can take a beat when it is empty or its beat leaves this edge.
   assign s2_load  = s1_valid_q && (!s2_valid_q || OUT_ready);
   assign IN_ready = !s1_valid_q || s2_load;
   assign in_fire  = IN_valid && IN_ready;

   for (genvar i = 0; i < NCH; i++) begin : g_lane
      addsub_acc_lane #(.N(N)) u_lane (
         .mode   (op_e'(s1_mode_q[2*i +: 2])),
         .a      (s1_a_q[N*i +: N]),
         .b      (s1_b_q[N*i +: N]),
         .acc    (acc_q[N*i +: N]),
         .clear  (IN_clear),
         .data   (lane_data[N*i +: N]),
         .carry  (lane_carry[i]),
         .acc_wr (lane_acc_wr[i]),
         .parity (lane_parity[i])
      );
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_mode_d  = s1_mode_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_mode_d  = IN_mode;
         s1_a_d     = IN_dataA;
         s1_b_d     = IN_dataB;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_data_d   = s2_data_q;
      s2_carry_d  = s2_carry_q;
      s2_parity_d = s2_parity_q;
      if (s2_load) begin
         s2_valid_d  = 1'b1;
         s2_data_d   = lane_data;
         s2_carry_d  = lane_carry;
         s2_parity_d = lane_parity;
      end else if (OUT_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   // Clear first, then a writing beat overrides it, so a colliding ACC/LOAD wins.
   always_comb begin
      acc_d = acc_q;
      for (int i = 0; i < NCH; i++) begin
         if (IN_clear) begin
            acc_d[N*i +: N] = '0;
         end
         if (s2_load && lane_acc_wr[i]) begin
            acc_d[N*i +: N] = lane_data[N*i +: N];
         end
      end
   end

   // NOTE: accumulators and the output payload are reset too, because they must read zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_mode_q   <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_data_q   <= '0;
         s2_carry_q  <= '0;
         s2_parity_q <= '0;
         acc_q       <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         s1_valid_q  <= s1_valid_d;
         s1_mode_q   <= s1_mode_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s2_valid_q  <= s2_valid_d;
         s2_data_q   <= s2_data_d;
         s2_carry_q  <= s2_carry_d;
         s2_parity_q <= s2_parity_d;
         acc_q       <= acc_d;
      end
   end

   assign OUT_valid  = s2_valid_q;
   assign OUT_data   = s2_data_q;
   assign OUT_carry  = s2_carry_q;
   assign OUT_parity = s2_parity_q;
endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Self-checking bench for addsub_acc_pipe: table vectors, directed corner sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_addsub_acc_pipe;
   localparam int N   = 32;
   localparam int NCH = 2;
   localparam int W   = N * NCH;

   localparam logic [1:0] ADD  = 2'd0;
   localparam logic [1:0] SUB  = 2'd1;
   localparam logic [1:0] ACC  = 2'd2;
   localparam logic [1:0] LOAD = 2'd3;

   typedef struct packed {
      logic [W-1:0]   data;
      logic [NCH-1:0] carry;
      logic [NCH-1:0] parity;
   } beat_t;

   typedef struct {
      logic [2*NCH-1:0] mode;
      logic [W-1:0]     a;
      logic [W-1:0]     b;
      beat_t            exp;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             IN_valid;
   logic             IN_ready;
   logic [2*NCH-1:0] IN_mode;
   logic [W-1:0]     IN_dataA;
   logic [W-1:0]     IN_dataB;
   logic             IN_clear;
   logic             OUT_valid;
   logic             OUT_ready;
   logic [W-1:0]     OUT_data;
   logic [NCH-1:0]   OUT_carry;
   logic [NCH-1:0]   OUT_parity;

   int    n_checks = 0;
   int    n_errors = 0;
   bit    mon_en   = 0;
   beat_t exp_q[$];
   logic [N-1:0] m_acc[NCH];

   addsub_acc_pipe #(.N(N), .NCH(NCH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .IN_valid   (IN_valid),
      .IN_ready   (IN_ready),
      .IN_mode    (IN_mode),
      .IN_dataA   (IN_dataA),
      .IN_dataB   (IN_dataB),
      .IN_clear   (IN_clear),
      .OUT_valid  (OUT_valid),
      .OUT_ready  (OUT_ready),
      .OUT_data   (OUT_data),
      .OUT_carry  (OUT_carry),
      .OUT_parity (OUT_parity)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference: plain wide arithmetic per lane; the accumulator follows acceptance order.
   task automatic model_push(input logic [2*NCH-1:0] mode, input logic [W-1:0] a, input logic [W-1:0] b);
      beat_t e;
      e = '0;
      for (int i = 0; i < NCH; i++) begin
         longint unsigned av, bv, total;
         av    = a[N*i +: N];
         bv    = b[N*i +: N];
         total = 0;
         case (mode[2*i +: 2])
            ADD: begin
               total      = av + bv;
               e.carry[i] = (total >= (64'd1 << N));
            end
            SUB: begin
               total      = av - bv;
               e.carry[i] = (av < bv);
            end
            ACC: begin
               total      = m_acc[i] + av + bv;
               e.carry[i] = (total >= (64'd1 << N));
               m_acc[i]   = total[N-1:0];
            end
            default: begin
               total    = av;
               m_acc[i] = av[N-1:0];
            end
         endcase
         e.data[N*i +: N] = total[N-1:0];
         e.parity[i]      = ($countones(av) % 2) == 1;
      end
      exp_q.push_back(e);
   endtask

   task automatic push_exp(input logic [W-1:0] data, input logic [NCH-1:0] carry, input logic [NCH-1:0] parity);
      beat_t e;
      e.data   = data;
      e.carry  = carry;
      e.parity = parity;
      exp_q.push_back(e);
   endtask

   task automatic drive_cycle(input logic v, input logic [2*NCH-1:0] mode, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic clr);
      IN_valid = v;
      IN_mode  = mode;
      IN_dataA = a;
      IN_dataB = b;
      IN_clear = clr;
      @(negedge clk);
      if (v) check("in_ready_accept", IN_ready, 1);
      @(posedge clk);
      #1;
      IN_valid = 1'b0;
      IN_clear = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         IN_valid = 1'b0;
         IN_clear = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [N-1:0] rand_word();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         2:       return N'($urandom_range(0, 15));
         default: return N'($urandom);
      endcase
   endfunction

   always @(negedge clk) begin
      beat_t e;
      if (mon_en && rst_n && OUT_valid && OUT_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got data %h, want no beat", OUT_data);
         end else begin
            e = exp_q.pop_front();
            check("out_data", OUT_data, e.data);
            check("out_carry", W'(OUT_carry), W'(e.carry));
            check("out_parity", W'(OUT_parity), W'(e.parity));
         end
      end
   end

   vec_t vecs[5];

   initial begin
      vecs[0] = '{mode: {SUB, ADD}, a: {32'd5, 32'd5}, b: {32'd3, 32'd3},
                  exp: {32'd2, 32'd8, 2'b00, 2'b00}};
      vecs[1] = '{mode: {SUB, ADD}, a: {32'd1, 32'hFFFF_FFFF}, b: {32'd2, 32'd2},
                  exp: {32'hFFFF_FFFF, 32'd1, 2'b11, 2'b10}};
      vecs[2] = '{mode: {ADD, SUB}, a: {32'h8000_0000, 32'd7}, b: {32'h8000_0000, 32'd7},
                  exp: {32'd0, 32'd0, 2'b10, 2'b11}};
      vecs[3] = '{mode: {LOAD, LOAD}, a: {32'hDEAD_BEEF, 32'h1234_5678}, b: {32'hFFFF_FFFF, 32'h0000_FFFF},
                  exp: {32'hDEAD_BEEF, 32'h1234_5678, 2'b00, 2'b01}};
      vecs[4] = '{mode: {ACC, ACC}, a: {32'h2152_4111, 32'd1}, b: {32'd0, 32'd2},
                  exp: {32'd0, 32'h1234_567B, 2'b10, 2'b11}};

      rst_n     = 1'b0;
      IN_valid  = 1'b0;
      IN_mode   = '0;
      IN_dataA  = '0;
      IN_dataB  = '0;
      IN_clear  = 1'b0;
      OUT_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      @(negedge clk);
      check("reset_out_valid", OUT_valid, 0);
      check("reset_out_data", OUT_data, 0);
      check("reset_out_carry", W'(OUT_carry), 0);
      check("reset_out_parity", W'(OUT_parity), 0);
      check("reset_in_ready", IN_ready, 1);
      @(posedge clk);
      #1;

      // Single beats through an empty pipe: nothing after one edge, result after two.
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, 1'b0);
         @(negedge clk);
         check("latency_not_early", OUT_valid, 0);
         @(posedge clk);
         #1;
         @(negedge clk);
         check("vec_valid", OUT_valid, 1);
         check("vec_data", OUT_data, vecs[i].exp.data);
         check("vec_carry", W'(OUT_carry), W'(vecs[i].exp.carry));
         check("vec_parity", W'(OUT_parity), W'(vecs[i].exp.parity));
         @(posedge clk);
         #1;
      end

      // Back-to-back accumulate stream on lane 0.
      mon_en = 1;
      push_exp({32'd0, 32'd10}, 2'b00, 2'b00);
      push_exp({32'd0, 32'd13}, 2'b00, 2'b01);
      push_exp({32'd0, 32'd20}, 2'b00, 2'b00);
      drive_cycle(1'b1, {ADD, LOAD}, {32'd0, 32'd10}, {32'd0, 32'd0}, 1'b0);
      drive_cycle(1'b1, {ADD, ACC}, {32'd0, 32'd1}, {32'd0, 32'd2}, 1'b0);
      drive_cycle(1'b1, {ADD, ACC}, {32'd0, 32'd3}, {32'd0, 32'd4}, 1'b0);
      @(negedge clk);
      check("stream_second_consecutive", OUT_valid, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("stream_third_consecutive", OUT_valid, 1);
      @(posedge clk);
      #1;
      idle(3);
      check("stream_all_out", exp_q.size(), 0);

      // Back-pressure: OUT_ready low for the first 5 cycles while 4 beats are offered.
      for (int i = 1; i <= 4; i++) begin
         push_exp({32'd100 - 32'(i), 32'd100 + 32'(i)}, 2'b00, {1'b1, 1'(($countones(i) % 2) == 1)});
      end
      begin
         int sent;
         sent = 0;
         for (int c = 0; c < 16; c++) begin
            OUT_ready = (c >= 5);
            IN_valid  = (sent < 4);
            IN_mode   = {SUB, ADD};
            IN_dataA  = {32'd100, 32'(sent + 1)};
            IN_dataB  = {32'(sent + 1), 32'd100};
            @(negedge clk);
            if (c == 2 || c == 4) check("bp_in_ready_low", IN_ready, 0);
            if (c >= 2 && c <= 4) begin
               check("bp_out_valid_held", OUT_valid, 1);
               check("bp_out_data_held", OUT_data, {32'd99, 32'd101});
            end
            if (IN_valid && IN_ready) sent++;
            @(posedge clk);
            #1;
         end
         IN_valid = 1'b0;
         check("bp_all_sent", sent, 4);
         check("bp_all_out", exp_q.size(), 0);
      end
      OUT_ready = 1'b1;

      // Clear collides with an ACC beat entering stage 2, then an isolated clear.
      push_exp({32'd0, 32'd100}, 2'b00, 2'b01);
      drive_cycle(1'b1, {ADD, LOAD}, {32'd0, 32'd100}, '0, 1'b0);
      idle(4);
      push_exp({32'd0, 32'd8}, 2'b00, 2'b01);
      drive_cycle(1'b1, {ADD, ACC}, {32'd0, 32'd7}, {32'd0, 32'd1}, 1'b0);
      drive_cycle(1'b0, '0, '0, '0, 1'b1);
      idle(4);
      push_exp({32'd0, 32'd8}, 2'b00, 2'b00);
      drive_cycle(1'b1, {ADD, ACC}, '0, '0, 1'b0);
      idle(4);
      drive_cycle(1'b0, '0, '0, '0, 1'b1);
      idle(2);
      push_exp({32'd0, 32'd2}, 2'b00, 2'b01);
      drive_cycle(1'b1, {ADD, ACC}, {32'd0, 32'd1}, {32'd0, 32'd1}, 1'b0);
      idle(4);
      check("clear_all_out", exp_q.size(), 0);

      // Asynchronous reset with two beats in flight.
      mon_en = 0;
      drive_cycle(1'b1, {ADD, LOAD}, {32'd0, 32'd50}, '0, 1'b0);
      drive_cycle(1'b1, {ADD, ACC}, {32'd0, 32'd1}, {32'd0, 32'd1}, 1'b0);
      check("pre_reset_in_flight", OUT_valid, 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_out_valid", OUT_valid, 0);
      check("async_reset_out_data", OUT_data, 0);
      check("async_reset_in_ready", IN_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("no_stale_beat", OUT_valid, 0);
         @(posedge clk);
         #1;
      end
      exp_q.delete();
      mon_en = 1;
      push_exp({32'd0, 32'd11}, 2'b00, 2'b00);
      drive_cycle(1'b1, {ADD, ACC}, {32'd0, 32'd5}, {32'd0, 32'd6}, 1'b0);
      idle(4);
      check("reset_acc_zero", exp_q.size(), 0);

      // Randomized traffic against the model; clear only while nothing is in flight.
      drive_cycle(1'b0, '0, '0, '0, 1'b1);
      for (int i = 0; i < NCH; i++) m_acc[i] = '0;
      for (int c = 0; c < 3000; c++) begin
         IN_valid  = ($urandom_range(0, 9) < 7);
         OUT_ready = ($urandom_range(0, 9) < 7);
         IN_mode   = (2*NCH)'($urandom);
         IN_dataA  = {rand_word(), rand_word()};
         IN_dataB  = {rand_word(), rand_word()};
         IN_clear  = (exp_q.size() == 0) && ($urandom_range(0, 19) == 0);
         @(negedge clk);
         if (IN_clear) begin
            for (int i = 0; i < NCH; i++) m_acc[i] = '0;
         end
         if (IN_valid && IN_ready) model_push(IN_mode, IN_dataA, IN_dataB);
         @(posedge clk);
         #1;
      end
      OUT_ready = 1'b1;
      idle(6);
      check("random_drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
